// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by fetch, decode and the hazard unit.
//   PC_WIDTH / INSTR_WIDTH : default program-counter and instruction widths
//   NOP_INSTR              : all-zero instruction issued as a pipeline bubble
//   opcode_e               : 3-bit opcode encodings shared with decode/HDU
package cpu_pkg;

    localparam int unsigned PC_WIDTH    = 16;
    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

    typedef enum logic [2:0] {
        OpNop = 3'b000,
        OpAdd = 3'b001,
        OpInc = 3'b011
    } opcode_e;

endpackage

// File: rtl/instr_fetch_pc_if.sv
// Fetch-stage signal bundle: control from HDU/later stages, the instruction ROM
// address/data pair and the IF/ID boundary towards decode.
//   master : the fetch stage (drives rom_addr and if_id_*)
//   slave  : the surrounding pipeline (drives stall/fetch_en/redirect_*, rom_q)
interface instr_fetch_pc_if #(
    parameter int unsigned PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int unsigned INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
);

    logic                   stall;
    logic                   fetch_en;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic [PC_WIDTH-1:0]    rom_addr;
    logic [INSTR_WIDTH-1:0] rom_q;
    logic [INSTR_WIDTH-1:0] if_id_instr;
    logic [PC_WIDTH-1:0]    if_id_pc;
    logic                   if_id_valid;

    modport master (
        input  stall,
        input  fetch_en,
        input  redirect_valid,
        input  redirect_pc,
        input  rom_q,
        output rom_addr,
        output if_id_instr,
        output if_id_pc,
        output if_id_valid
    );

    modport slave (
        output stall,
        output fetch_en,
        output redirect_valid,
        output redirect_pc,
        output rom_q,
        input  rom_addr,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_valid
    );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter for fetch-stage statistics.
// Only compiled when FETCH_PERF_CNT_EN is defined; otherwise this file is empty
// so the default build carries no unused module.
//   clk     : clock
//   reset   : asynchronous active-high reset, clears the count
//   inc_i   : count one event this cycle
//   count_o : current count, sticks at all-ones
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/instr_fetch_pc.sv
// Program counter and fetch stage. Drives the address of the 1-cycle-latency
// instruction ROM and presents the fetched word, its PC and a valid flag to decode.
//   clk            : single clock
//   reset          : asynchronous active-high reset
//   bus (master)   : stall/fetch_en/redirect_* in, rom_addr out, rom_q in,
//                    if_id_instr/if_id_pc/if_id_valid out
//   perf_fetch_cnt : (FETCH_PERF_CNT_EN only) words consumed by decode
//   perf_stall_cnt : (FETCH_PERF_CNT_EN only) cycles a valid word sat stalled
// Optional feature macro: FETCH_PERF_CNT_EN adds the two saturating counters.
module instr_fetch_pc #(
    parameter int unsigned          PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int unsigned          INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]             perf_fetch_cnt,
    output logic [31:0]             perf_stall_cnt,
`endif
    instr_fetch_pc_if.master        bus
);

    import cpu_pkg::*;

    // fetch_pc_q is the address whose ROM data is currently on rom_q.
    logic [PC_WIDTH-1:0] fetch_pc_d, fetch_pc_q;
    logic                valid_d, valid_q;
    logic                advance;
    logic [PC_WIDTH-1:0] base_pc;
    logic [PC_WIDTH-1:0] rom_addr;

    always_comb begin
        // Decode takes the current word only if it is real and not held by the HDU.
        advance = valid_q & ~bus.stall;
        base_pc = advance ? fetch_pc_q + PC_WIDTH'(1) : fetch_pc_q;

        // reset is in this mux so the ROM sees RESET_PC while the flops are cleared.
        if (reset) begin
            rom_addr = RESET_PC;
        end else if (bus.redirect_valid) begin
            rom_addr = bus.redirect_pc;
        end else begin
            rom_addr = base_pc;
        end

        // The ROM registers rom_addr on the same edge, so its data matches fetch_pc_q.
        fetch_pc_d = rom_addr;

        // A redirect overrides a stall: the stalled word is flushed downstream.
        if (bus.stall && !bus.redirect_valid) begin
            valid_d = valid_q;
        end else begin
            valid_d = bus.fetch_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.rom_addr    = rom_addr;
    assign bus.if_id_valid = valid_q;
    assign bus.if_id_pc    = fetch_pc_q;
    assign bus.if_id_instr = valid_q ? bus.rom_q : INSTR_WIDTH'(NOP_INSTR);

`ifdef FETCH_PERF_CNT_EN
    logic stall_evt;
    assign stall_evt = valid_q & bus.stall;

    fetch_perf_cnt #(
        .Width (32)
    ) u_fetch_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (advance),
        .count_o (perf_fetch_cnt)
    );

    fetch_perf_cnt #(
        .Width (32)
    ) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (stall_evt),
        .count_o (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_pc.sv
// Self-checking bench for instr_fetch_pc with a behavioural 1-cycle ROM
// (ROM[n] = n + 100) and a cycle model feeding a scoreboard queue.
module tb_instr_fetch_pc;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [31:0] instr;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_pc_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instr_fetch_pc #(
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .bus            (bus)
    );

    function automatic logic [31:0] rom_fn(input logic [15:0] a);
        return {16'h0000, a} + 32'd100;
    endfunction

    always @(posedge clk) bus.rom_q <= rom_fn(bus.rom_addr);

    // Bench model of the fetch stage.
    logic [15:0] m_pc;
    logic        m_valid;
    logic [31:0] m_fcnt;
    logic [31:0] m_scnt;
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_valid = 1'b0;
        m_fcnt  = 32'd0;
        m_scnt  = 32'd0;
        sb.delete();
    endtask

    // One clock cycle: drive inputs just after negedge, check rom_addr, push the
    // predicted IF/ID contents, then pop and compare them at the next negedge.
    task automatic cycle(input logic s, input logic fe, input logic rv,
                         input logic [15:0] rpc, input string tag);
        exp_t        e;
        logic        adv;
        logic [15:0] exp_addr;
        bus.stall          = s;
        bus.fetch_en       = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        adv      = m_valid & ~s;
        exp_addr = rv ? rpc : (adv ? m_pc + 16'd1 : m_pc);
        n_checks++;
        if (bus.rom_addr !== exp_addr) begin
            n_errors++;
            $display("FAIL %s rom_addr got %h exp %h", tag, bus.rom_addr, exp_addr);
        end
        if (adv && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
        if (m_valid && s && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
        if (!(s && !rv)) m_valid = fe;
        m_pc    = exp_addr;
        e.valid = m_valid;
        e.pc    = m_pc;
        e.instr = m_valid ? rom_fn(m_pc) : 32'h0;
        e.fcnt  = m_fcnt;
        e.scnt  = m_scnt;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (bus.if_id_valid !== e.valid) begin
            n_errors++;
            $display("FAIL %s valid got %b exp %b", tag, bus.if_id_valid, e.valid);
        end
        n_checks++;
        if (bus.if_id_pc !== e.pc) begin
            n_errors++;
            $display("FAIL %s pc got %h exp %h", tag, bus.if_id_pc, e.pc);
        end
        n_checks++;
        if (bus.if_id_instr !== e.instr) begin
            n_errors++;
            $display("FAIL %s instr got %h exp %h", tag, bus.if_id_instr, e.instr);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (perf_fetch_cnt !== e.fcnt) begin
            n_errors++;
            $display("FAIL %s fetch_cnt got %0d exp %0d", tag, perf_fetch_cnt, e.fcnt);
        end
        n_checks++;
        if (perf_stall_cnt !== e.scnt) begin
            n_errors++;
            $display("FAIL %s stall_cnt got %0d exp %0d", tag, perf_stall_cnt, e.scnt);
        end
`endif
    endtask

    task automatic test_reset();
        bus.stall          = 1'b0;
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h1234;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.if_id_valid !== 1'b0 || bus.if_id_pc !== 16'h0000 ||
            bus.if_id_instr !== 32'h0 || bus.rom_addr !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_state got v=%b pc=%h i=%h a=%h exp v=0 pc=0000 i=0 a=0000",
                     bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, bus.rom_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.fetch_en       = 1'b1;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.if_id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL first_cycle_valid got %b exp 0", bus.if_id_valid);
        end
    endtask

    task automatic test_startup();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 16'h0, "startup");
            n_checks++;
            if (bus.if_id_pc !== 16'(i) || bus.if_id_instr !== 32'(100 + i)) begin
                n_errors++;
                $display("FAIL startup_seq got pc=%h i=%0d exp pc=%h i=%0d",
                         bus.if_id_pc, bus.if_id_instr, 16'(i), 100 + i);
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 16'h0, "stall");
            n_checks++;
            if (bus.if_id_pc !== 16'd2 || bus.if_id_instr !== 32'd102 || bus.rom_addr !== 16'd2) begin
                n_errors++;
                $display("FAIL stall_hold got pc=%h i=%0d a=%h exp pc=0002 i=102 a=0002",
                         bus.if_id_pc, bus.if_id_instr, bus.rom_addr);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 16'h0, "unstall");
        n_checks++;
        if (bus.if_id_pc !== 16'd3) begin
            n_errors++;
            $display("FAIL stall_release got pc=%h exp 0003", bus.if_id_pc);
        end
    endtask

    task automatic test_redirect();
        cycle(1'b0, 1'b1, 1'b0, 16'h0, "to5");
        cycle(1'b0, 1'b1, 1'b0, 16'h0, "to5");
        cycle(1'b1, 1'b1, 1'b1, 16'h0040, "redir_stall");
        n_checks++;
        if (bus.if_id_pc !== 16'h0040 || bus.if_id_valid !== 1'b1 ||
            bus.if_id_instr !== rom_fn(16'h0040)) begin
            n_errors++;
            $display("FAIL redirect_target got pc=%h v=%b i=%h exp pc=0040 v=1 i=%h",
                     bus.if_id_pc, bus.if_id_valid, bus.if_id_instr, rom_fn(16'h0040));
        end
        cycle(1'b0, 1'b1, 1'b0, 16'h0, "redir_next");
        n_checks++;
        if (bus.if_id_pc !== 16'h0041) begin
            n_errors++;
            $display("FAIL redirect_next got pc=%h exp 0041", bus.if_id_pc);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want [4];
        want[0] = 16'hFFFE;
        want[1] = 16'hFFFF;
        want[2] = 16'h0000;
        want[3] = 16'h0001;
        cycle(1'b0, 1'b1, 1'b1, 16'hFFFE, "wrap");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycle(1'b0, 1'b1, 1'b0, 16'h0, "wrap");
            n_checks++;
            if (bus.if_id_pc !== want[i]) begin
                n_errors++;
                $display("FAIL wrap_seq got pc=%h exp %h", bus.if_id_pc, want[i]);
            end
        end
    endtask

    task automatic test_pause();
        cycle(1'b0, 1'b1, 1'b1, 16'h0007, "to7");
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0, "pause");
            n_checks++;
            if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0 || bus.if_id_pc !== 16'd8) begin
                n_errors++;
                $display("FAIL pause_bubble got v=%b i=%h pc=%h exp v=0 i=0 pc=0008",
                         bus.if_id_valid, bus.if_id_instr, bus.if_id_pc);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 16'h0, "resume");
        n_checks++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 16'd8 || bus.if_id_instr !== 32'd108) begin
            n_errors++;
            $display("FAIL pause_resume got v=%b pc=%h i=%0d exp v=1 pc=0008 i=108",
                     bus.if_id_valid, bus.if_id_pc, bus.if_id_instr);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 9) == 0), 16'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b1, 1'b1, 16'h0009, "to9");
        n_checks++;
        if (bus.if_id_pc !== 16'h0009 || bus.if_id_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset got pc=%h v=%b exp pc=0009 v=1", bus.if_id_pc, bus.if_id_valid);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (perf_fetch_cnt !== m_fcnt || perf_stall_cnt !== m_scnt) begin
            n_errors++;
            $display("FAIL pre_reset_cnt got %0d/%0d exp %0d/%0d",
                     perf_fetch_cnt, perf_stall_cnt, m_fcnt, m_scnt);
        end
`endif
        bus.stall          = 1'b0;
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0ABC;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.if_id_valid !== 1'b0 || bus.if_id_pc !== 16'h0000 ||
            bus.if_id_instr !== 32'h0 || bus.rom_addr !== 16'h0000) begin
            n_errors++;
            $display("FAIL mid_reset got v=%b pc=%h i=%h a=%h exp v=0 pc=0000 i=0 a=0000",
                     bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, bus.rom_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL mid_reset_cnt got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.if_id_valid !== 1'b0 || bus.if_id_pc !== 16'h0000) begin
            n_errors++;
            $display("FAIL post_reset got v=%b pc=%h exp v=0 pc=0000", bus.if_id_valid, bus.if_id_pc);
        end
        cycle(1'b0, 1'b1, 1'b0, 16'h0, "post_reset");
        n_checks++;
        if (bus.if_id_pc !== 16'h0000 || bus.if_id_instr !== 32'd100) begin
            n_errors++;
            $display("FAIL post_reset_fetch got pc=%h i=%0d exp pc=0000 i=100",
                     bus.if_id_pc, bus.if_id_instr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_wrap();
        test_pause();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
